// File: rtl/layered_color_mapper.sv
// Layered color mapper: resolves prioritised sprite layers through a shared
// writable palette, applies per-layer hit-flash inversion and falls back to a
// ground/gradient background. Two-stage registered pipeline with delayed blank.
module layered_color_mapper #(
  parameter int          NUM_LAYERS   = 4,
  parameter int          IDX_W        = 4,
  parameter int          GROUND_Y     = 380,
  parameter logic [23:0] GROUND_RGB   = 24'h00FF00,
  parameter logic [7:0]  BG_RED       = 8'h3F,
  parameter int          FLASH_FRAMES = 8
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic                        blank_n,
  input  logic                        frame_start,
  input  logic [NUM_LAYERS-1:0]       layer_hit,
  input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
  input  logic [NUM_LAYERS-1:0]       flash_trig,
  input  logic                        pal_we,
  input  logic [IDX_W-1:0]            pal_addr,
  input  logic [23:0]                 pal_wdata,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B,
  output logic                        out_blank_n,
  output logic [NUM_LAYERS-1:0]       flash_active
);

  localparam int              PAL_DEPTH  = 1 << IDX_W;
  localparam int              LAYER_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int              CNT_W      = $clog2(FLASH_FRAMES + 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_FRAMES);
  localparam logic [9:0]      GROUND_Y_L = 10'(GROUND_Y);

  logic [23:0]        palette [PAL_DEPTH];
  logic [CNT_W-1:0]   flash_cnt [NUM_LAYERS];

  logic               hit_any;
  logic [LAYER_W-1:0] hit_layer;
  logic [IDX_W-1:0]   hit_idx;
  logic [23:0]        bg_rgb;

  logic               s1_valid;
  logic [LAYER_W-1:0] s1_layer;
  logic [IDX_W-1:0]   s1_idx;
  logic [23:0]        s1_bg;
  logic               s1_blank_n;

  logic [23:0]        color_next;
  logic               unused_bits;

  // The low three column bits only matter at finer than 8-pixel gradient steps.
  assign unused_bits = ^DrawX[2:0];

  // Priority encoder: scanning downward lets the lowest hitting layer win.
  always_comb begin
    hit_any   = |layer_hit;
    hit_layer = '0;
    hit_idx   = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_hit[i]) begin
        hit_layer = LAYER_W'(i);
        hit_idx   = layer_idx[i*IDX_W +: IDX_W];
      end
    end
  end

  // Background: flat ground below the horizon, otherwise a blue column gradient.
  always_comb begin
    bg_rgb = {BG_RED, 8'h00, 8'h7F - {1'b0, DrawX[9:3]}};
    if (DrawY >= GROUND_Y_L) begin
      bg_rgb = GROUND_RGB;
    end
  end

  // Palette storage; reads see the pre-write contents within the write cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        palette[i] <= '0;
      end
    end else if (pal_we) begin
      palette[pal_addr] <= pal_wdata;
    end
  end

  // Per-layer flash counters: a trigger reloads, frame pulses count down to zero.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        flash_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (flash_trig[i]) begin
          flash_cnt[i] <= FLASH_LOAD;
        end else if (frame_start && (flash_cnt[i] != '0)) begin
          flash_cnt[i] <= flash_cnt[i] - 1'b1;
        end
      end
    end
  end

  // Registered status flags, one cycle behind the counters.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      flash_active <= '0;
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        flash_active[i] <= (flash_cnt[i] != '0);
      end
    end
  end

  // Stage 1: capture the layer selection, background and blank for this pixel.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid   <= 1'b0;
      s1_layer   <= '0;
      s1_idx     <= '0;
      s1_bg      <= '0;
      s1_blank_n <= 1'b0;
    end else begin
      s1_valid   <= hit_any;
      s1_layer   <= hit_layer;
      s1_idx     <= hit_idx;
      s1_bg      <= bg_rgb;
      s1_blank_n <= blank_n;
    end
  end

  // Stage 2 color: palette lookup with live flash state, background, then blanking.
  always_comb begin
    color_next = s1_bg;
    if (s1_valid) begin
      color_next = palette[s1_idx];
      if (flash_cnt[s1_layer] != '0) begin
        color_next = ~color_next;
      end
    end
    if (!s1_blank_n) begin
      color_next = '0;
    end
  end

  // Stage 2 register: drive the VGA pins and the aligned blank.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      out_blank_n <= 1'b0;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= color_next;
      out_blank_n           <= s1_blank_n;
    end
  end

endmodule
